// File: rtl/fc_addrgen_multi_pkg.sv
// Shared layer constants, default widths and FSM encoding for the
// multi-lane FC address generator.
package fc_addrgen_multi_pkg;

    localparam int unsigned DEF_ADDR_WIDTH   = 8;
    localparam int unsigned DEF_W_ADDR_WIDTH = 10;
    localparam int unsigned DEF_INNEURON     = 64;
    localparam int unsigned DEF_OUTNEURON    = 32;
    localparam int unsigned DEF_PI           = 4;
    localparam int unsigned DEF_PO           = 8;
    localparam int unsigned DEF_NPORTS       = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    function automatic int unsigned cdiv(input int unsigned a,
                                         input int unsigned b);
        return (a + b - 1) / b;
    endfunction

    // Counter width that stays legal when the count is 1.
    function automatic int unsigned cw(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fc_loop_counter.sv
// Generic wrap counter: counts 0..MAX on inc, wraps to 0, flags the wrap.
module fc_loop_counter #(
    parameter int unsigned W   = 1,
    parameter int unsigned MAX = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign wrap = inc && (cnt_q == W'(MAX));
    assign cnt  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = wrap ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fc_addrgen_multi.sv
// FC layer address generator: tile/step loops issuing NPORTS input-buffer
// addresses plus one weight address per beat, with first/last markers.
module fc_addrgen_multi
    import fc_addrgen_multi_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int unsigned W_ADDR_WIDTH = DEF_W_ADDR_WIDTH,
    parameter int unsigned INNEURON     = DEF_INNEURON,
    parameter int unsigned OUTNEURON    = DEF_OUTNEURON,
    parameter int unsigned PI           = DEF_PI,
    parameter int unsigned PO           = DEF_PO,
    parameter int unsigned NPORTS       = DEF_NPORTS
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         enable,
    input  logic                         clear,
    output logic [NPORTS*ADDR_WIDTH-1:0] in_addr,
    output logic [NPORTS-1:0]            lane_mask,
    output logic [W_ADDR_WIDTH-1:0]      w_addr,
    output logic                         addr_valid,
    output logic                         first,
    output logic                         last,
    output logic                         busy,
    output logic                         done
);

    localparam int unsigned WORDS = cdiv(INNEURON, PI);
    localparam int unsigned STEPS = cdiv(WORDS, NPORTS);
    localparam int unsigned TILES = cdiv(OUTNEURON, PO);
    localparam int unsigned SW    = cw(STEPS);
    localparam int unsigned TW    = cw(TILES);

    state_e state_q, state_d;

    logic [SW-1:0] step_cnt;
    logic [TW-1:0] tile_cnt;
    logic          step_wrap;
    logic          tile_wrap;
    logic          beat;

    logic [NPORTS*ADDR_WIDTH-1:0] in_addr_q, in_addr_d;
    logic [NPORTS-1:0]            lane_mask_q, lane_mask_d;
    logic [W_ADDR_WIDTH-1:0]      w_addr_q, w_addr_d;
    logic                         addr_valid_q, addr_valid_d;
    logic                         first_q, first_d;
    logic                         last_q, last_d;
    logic                         done_q, done_d;
    logic [ADDR_WIDTH-1:0]        lane;

    // clear outranks enable, so an aborted cycle never issues a beat.
    assign beat = (state_q == ST_RUN) && enable && !clear;

    fc_loop_counter #(.W(SW), .MAX(STEPS - 1)) u_step (
        .clk  (clk),
        .rst  (reset),
        .inc  (beat),
        .clr  (clear),
        .cnt  (step_cnt),
        .wrap (step_wrap)
    );

    fc_loop_counter #(.W(TW), .MAX(TILES - 1)) u_tile (
        .clk  (clk),
        .rst  (reset),
        .inc  (step_wrap),
        .clr  (clear),
        .cnt  (tile_cnt),
        .wrap (tile_wrap)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (tile_wrap) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (clear) state_d = ST_IDLE;
    end

    always_comb begin
        in_addr_d    = in_addr_q;
        lane_mask_d  = lane_mask_q;
        w_addr_d     = w_addr_q;
        first_d      = first_q;
        last_d       = last_q;
        lane         = '0;
        addr_valid_d = beat;
        done_d       = (state_q == ST_DONE) && !clear;
        if (beat) begin
            for (int k = 0; k < NPORTS; k++) begin
                lane = ADDR_WIDTH'(step_cnt) * ADDR_WIDTH'(NPORTS)
                     + ADDR_WIDTH'(k);
                in_addr_d[k*ADDR_WIDTH +: ADDR_WIDTH] = lane;
                lane_mask_d[k] = 32'(lane) < WORDS;
            end
            w_addr_d = W_ADDR_WIDTH'(tile_cnt) * W_ADDR_WIDTH'(STEPS)
                     + W_ADDR_WIDTH'(step_cnt);
            first_d  = (step_cnt == '0);
            last_d   = (step_cnt == SW'(STEPS - 1));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            in_addr_q    <= '0;
            lane_mask_q  <= '0;
            w_addr_q     <= '0;
            addr_valid_q <= 1'b0;
            first_q      <= 1'b0;
            last_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_addr_q    <= in_addr_d;
            lane_mask_q  <= lane_mask_d;
            w_addr_q     <= w_addr_d;
            addr_valid_q <= addr_valid_d;
            first_q      <= first_d;
            last_q       <= last_d;
            done_q       <= done_d;
        end
    end

    assign in_addr    = in_addr_q;
    assign lane_mask  = lane_mask_q;
    assign w_addr     = w_addr_q;
    assign addr_valid = addr_valid_q;
    assign first      = first_q;
    assign last       = last_q;
    assign done       = done_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fc_addrgen_multi.sv
// Directed bench: default 2-lane config plus a 4-lane config with a
// partial final word, both driven from the same control inputs.
module tb_fc_addrgen_multi;

    logic        clk;
    logic        reset;
    logic        start;
    logic        enable;
    logic        clear;

    logic [15:0] in_addr;
    logic [1:0]  lane_mask;
    logic [9:0]  w_addr;
    logic        addr_valid, first, last, busy, done;

    logic [31:0] in_addr2;
    logic [3:0]  lane_mask2;
    logic [9:0]  w_addr2;
    logic        addr_valid2, first2, last2, busy2, done2;

    int n_cmp;
    int n_bad;

    fc_addrgen_multi dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .enable     (enable),
        .clear      (clear),
        .in_addr    (in_addr),
        .lane_mask  (lane_mask),
        .w_addr     (w_addr),
        .addr_valid (addr_valid),
        .first      (first),
        .last       (last),
        .busy       (busy),
        .done       (done)
    );

    fc_addrgen_multi #(.INNEURON(40), .PI(4), .NPORTS(4)) dut2 (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .enable     (enable),
        .clear      (clear),
        .in_addr    (in_addr2),
        .lane_mask  (lane_mask2),
        .w_addr     (w_addr2),
        .addr_valid (addr_valid2),
        .first      (first2),
        .last       (last2),
        .busy       (busy2),
        .done       (done2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_in_addr"}, in_addr, 0);
        check({tag, "_mask"}, lane_mask, 0);
        check({tag, "_w_addr"}, w_addr, 0);
        check({tag, "_valid"}, addr_valid, 0);
        check({tag, "_first"}, first, 0);
        check({tag, "_last"}, last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_in_addr2"}, in_addr2, 0);
        check({tag, "_w_addr2"}, w_addr2, 0);
        check({tag, "_ctl2"}, {lane_mask2, addr_valid2, first2, last2,
                               busy2, done2}, 0);
    endtask

    // One full pass: 32 beats on dut (8x4), 12 beats on dut2 (3x4).
    task automatic pass(input bit toggle, input bit start_mid);
        int b;
        int b2;
        int s;
        bit prev_en;
        b  = 0;
        b2 = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        enable  = 1'b1;
        prev_en = 1'b1;
        @(negedge clk);
        for (int cyc = 0; cyc < 200 && b < 32; cyc++) begin
            check("valid_vs_enable", addr_valid, prev_en);
            if (addr_valid) begin
                s = b % 8;
                check("lanes", in_addr, {16'd0, 8'(s*2+1), 8'(s*2)});
                check("w_addr", w_addr, b);
                check("mask", lane_mask, 2'b11);
                check("first", first, s == 0);
                check("last", last, s == 7);
                b++;
            end
            if (addr_valid2) begin
                s = b2 % 3;
                check("lanes2", in_addr2,
                      {8'(s*4+3), 8'(s*4+2), 8'(s*4+1), 8'(s*4)});
                check("mask2", lane_mask2, (s == 2) ? 4'b0011 : 4'b1111);
                check("w_addr2", w_addr2, b2);
                check("first2", first2, s == 0);
                check("last2", last2, s == 2);
                b2++;
            end
            if (b < 32) begin
                enable  = toggle ? ~enable : 1'b1;
                start   = start_mid && (cyc == 5);
                prev_en = enable;
                @(negedge clk);
            end
        end
        check("beat_count", b, 32);
        check("beat_count2", b2, 12);
        enable = 1'b0;
        start  = 1'b0;
        @(negedge clk);
        check("done_pulse", done, 1);
        check("busy_at_done", busy, 0);
        check("valid_at_done", addr_valid, 0);
        @(negedge clk);
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        bit found;
        n_cmp  = 0;
        n_bad  = 0;
        reset  = 1'b0;
        start  = 1'b0;
        enable = 1'b0;
        clear  = 1'b0;
        #1 reset = 1'b1;
        #1 check_zero("rst");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_zero("idle");

        pass(1'b0, 1'b0);
        pass(1'b1, 1'b0);
        pass(1'b0, 1'b1);

        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        enable = 1'b1;
        found  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (addr_valid && w_addr == 10'd13) begin
                found = 1'b1;
                break;
            end
        end
        check("reach_w13", found, 1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        enable = 1'b0;
        check("clr_valid", addr_valid, 0);
        check("clr_busy", busy, 0);
        check("clr_w_hold", w_addr, 13);
        @(negedge clk);
        check("clr_no_done", done, 0);
        check("clr_idle", busy, 0);
        pass(1'b0, 1'b0);

        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        enable = 1'b1;
        repeat (5) @(negedge clk);
        check("run_before_arst", addr_valid, 1);
        #2 reset = 1'b1;
        #1 check_zero("arst");
        @(negedge clk);
        reset  = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        check_zero("arst_idle");
        pass(1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
